axi_lite_mem_mmio_bridge: RTL and testbench
===========================================

Name: axi_lite_mem_mmio_bridge

Overview:
- AXI4-Lite slave bridging a host CPU to the soft CPU's instruction/data memory and a small MMIO register file.
- Parametrised in address, data and memory-region width.
- Accepts AW and W independently, honours WSTRB, returns SLVERR on unmapped addresses.
- Adds a soft-CPU cycle counter.

Parameters:
- ADDR_WIDTH, 14: AXI byte-address width. Bit ADDR_WIDTH-1 selects memory (0) or MMIO (1).
- DATA_WIDTH, 32: AXI data width. Allowed values are 32 and 64.
- MEM_ADDR_WIDTH, 13: byte-address bits of the memory region. Must be <= ADDR_WIDTH-1.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWVALID  in  1  write-address valid
- S_AXI_AWREADY  out  1  write-address ready
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  write byte strobes
- S_AXI_WVALID  in  1  write-data valid
- S_AXI_WREADY  out  1  write-data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write-response valid
- S_AXI_BREADY  in  1  write-response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  read-address valid
- S_AXI_ARREADY  out  1  read-address ready
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read-data valid
- S_AXI_RREADY  in  1  read-data ready
- mem_addr  out  MEM_ADDR_WIDTH-log2(DATA_WIDTH/8)  memory word index
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_wstrb  out  DATA_WIDTH/8  memory byte enables
- mem_wen  out  1  memory write strobe, one cycle
- mem_ren  out  1  memory read strobe, one cycle
- mem_rdata  in  DATA_WIDTH  memory read data, combinational read
- cpu_status  in  DATA_WIDTH  soft-CPU status word
- cpu_rst  out  1  soft-CPU reset, active high

Behaviour:
- Clock and reset: single clock S_AXI_ACLK. Reset S_AXI_ARESETN is asynchronous, active-low.
- While reset is low:
  - all READY/VALID outputs are 0; RDATA, BRESP, RRESP are 0.
  - cpu_rst = 1; cycle counter = 0; all holding registers are empty.
  - mem_wen and mem_ren are 0.
  - Reset mid-transaction discards held requests and pending responses.
- Write holding registers: AW and W each have a one-entry holding register.
  - AWREADY = ~aw_full. WREADY = ~w_full. Both are low during reset.
  - A handshake fills the matching register at the clock edge. AW may precede W or follow it by any number of cycles.
- Write execute cycle: the first cycle with aw_full & w_full & ~BVALID.
  - Memory target: mem_wen=1, mem_wstrb=held WSTRB, mem_wdata=held WDATA, mem_addr=held address word index.
  - At the closing edge: both holding registers clear, BVALID=1, BRESP set.
  - BVALID holds until BREADY. A new execute cannot start while BVALID=1.
  - Minimum latency: AW and W together in cycle 0, execute in cycle 1, BVALID in cycle 2.
- Read path:
  - ARREADY = ~ar_full & ~RVALID.
  - Read execute occurs in a cycle with ar_full and no write execute (write has priority; the read stalls one cycle).
  - Read execute: mem_ren=1 for memory targets; RDATA, RRESP captured; RVALID=1; ar_full clears.
  - RVALID holds until RREADY. RDATA is stable while RVALID=1.
- Address decode:
  - Memory region: address bit ADDR_WIDTH-1 = 0. Bits above MEM_ADDR_WIDTH-1 are ignored (aliasing).
  - MMIO region: address bit ADDR_WIDTH-1 = 1, offset = low address bits.
  - 0x0 CTRL (R/W). Bit0 write 1 deasserts cpu_rst, write 0 asserts it. Updated only when WSTRB[0]=1. Reads {0..., ~cpu_rst}.
  - 0x4 STATUS (RO). Reads cpu_status. Writes are ignored with OKAY.
  - 0x8 CYCLE (R/W). Increments by 1 every cycle while cpu_rst=0 and wraps from all-ones to 0. Any write with a non-zero strobe clears it to 0; clear wins over increment in the same cycle. Held at its value while cpu_rst=1.
  - Any other MMIO offset: response SLVERR (2'b10), RDATA=0, no side effect.
  - Responses are OKAY (2'b00) otherwise.
- Unaligned low address bits are ignored.
- Simultaneous AW/W/AR acceptance in one cycle is legal.

Test Plan:
- AW+W at memory address 0x0010, WDATA=0xDEADBEEF, WSTRB=0xF → mem_wen for one cycle with mem_addr=4; BVALID in cycle 2, BRESP=0. Then AR 0x0010 with mem_rdata=0xDEADBEEF → RVALID one cycle after the AR handshake, RDATA=0xDEADBEEF.
- W issued 3 cycles before AW, with BREADY held low 5 cycles → WREADY=0 after the W handshake, no execute until AW arrives, BVALID held 5 cycles. A second AW/W pair is held but not executed until after the B handshake.
- Write 0x1 to MMIO 0x2000 with WSTRB=0x1 → cpu_rst goes 0; CYCLE read 10 cycles later ≥ 10. Write to 0x2008 → next CYCLE read returns a small value (≤ 2 + read latency).
- Write 0x1 to 0x2000 with WSTRB=0x0 → cpu_rst stays 1. Read 0x200C → RRESP=2'b10, RDATA=0. Write 0x2010 → BRESP=2'b10.
- AR and a write execute in the same cycle → mem_wen in cycle N, mem_ren in cycle N+1, both responses correct.
- Drop S_AXI_ARESETN mid-write (AW held, W pending) → all outputs return to reset values immediately, without waiting for a clock edge; no mem_wen after reset release.

Source files
------------

// File: rtl/axi_lite_mem_mmio_bridge.sv
// AXI4-Lite slave that bridges a host CPU onto the soft CPU's memory port
// and a small MMIO register file (CTRL, STATUS, CYCLE).
//
// Handshake rules: a transfer happens on a rising clock edge where VALID
// and READY are both high. Each channel has its own one-entry holding register.
// VALID outputs (BVALID, RVALID) stay high until the matching READY is seen.
// RDATA and RRESP do not change while RVALID is high.
// A write executes when both the address and the data are held and no
// response is waiting. A read executes in any cycle without a write
// execute, because a write has priority on the shared memory port.
module axi_lite_mem_mmio_bridge #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 13
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]         S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]         S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]         S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [MEM_ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_wstrb,
    output logic                          mem_wen,
    output logic                          mem_ren,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic [DATA_WIDTH-1:0]         cpu_status,
    output logic                          cpu_rst
);

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int BYTE_OFF  = $clog2(STRB_W);
    localparam int MEM_IDX_W = MEM_ADDR_WIDTH - BYTE_OFF;
    // MMIO registers are 32-bit spaced; the index drops the two byte bits
    localparam int RIDX_W    = ADDR_WIDTH - 3;

    localparam logic [RIDX_W-1:0] REG_CTRL   = RIDX_W'(0);
    localparam logic [RIDX_W-1:0] REG_STATUS = RIDX_W'(1);
    localparam logic [RIDX_W-1:0] REG_CYCLE  = RIDX_W'(2);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Holding registers and response state
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q,  w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
    logic [STRB_W-1:0]     w_strb_q,  w_strb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic [DATA_WIDTH-1:0] cycle_q,   cycle_d;

    // Decoded views of the held addresses
    logic                  wr_exec;
    logic                  rd_exec;
    logic                  aw_is_mmio;
    logic                  ar_is_mmio;
    logic [RIDX_W-1:0]     aw_reg;
    logic [RIDX_W-1:0]     ar_reg;
    logic [MEM_IDX_W-1:0]  aw_word;
    logic [MEM_IDX_W-1:0]  ar_word;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;

    // Address bits above the memory window and below the word/register
    // granularity are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{aw_addr_q, ar_addr_q};

    assign aw_is_mmio = aw_addr_q[ADDR_WIDTH-1];
    assign ar_is_mmio = ar_addr_q[ADDR_WIDTH-1];
    assign aw_reg     = aw_addr_q[ADDR_WIDTH-2:2];
    assign ar_reg     = ar_addr_q[ADDR_WIDTH-2:2];
    assign aw_word    = aw_addr_q[MEM_ADDR_WIDTH-1:BYTE_OFF];
    assign ar_word    = ar_addr_q[MEM_ADDR_WIDTH-1:BYTE_OFF];

    assign wr_exec = aw_full_q & w_full_q & ~bvalid_q;
    assign rd_exec = ar_full_q & ~rvalid_q & ~wr_exec;

    // READY outputs are forced low while reset is asserted
    assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_full_q;
    assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_full_q;
    assign S_AXI_ARREADY = S_AXI_ARESETN & ~ar_full_q & ~rvalid_q;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign cpu_rst      = cpu_rst_q;

    // Memory port: the write execute owns the address in its cycle
    always_comb begin
        mem_wen   = wr_exec & ~aw_is_mmio;
        mem_ren   = rd_exec & ~ar_is_mmio;
        mem_wdata = w_data_q;
        mem_wstrb = w_strb_q;
        mem_addr  = wr_exec ? aw_word : ar_word;
    end

    // Next-state logic for holding registers, responses and MMIO state
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ar_full_d = ar_full_q;
        ar_addr_d = ar_addr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        cpu_rst_d = cpu_rst_q;
        cycle_d   = cpu_rst_q ? cycle_q : cycle_q + DATA_WIDTH'(1);

        // Channel acceptance
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_addr_d = S_AXI_ARADDR;
        end

        // Response retirement
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        // Write execute: consume both holding registers, raise BVALID
        if (wr_exec) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            if (aw_is_mmio) begin
                case (aw_reg)
                    REG_CTRL: begin
                        if (w_strb_q[0]) begin
                            cpu_rst_d = ~w_data_q[0];
                        end
                    end
                    REG_STATUS: begin
                        // read-only: write is accepted and dropped
                    end
                    REG_CYCLE: begin
                        // clearing takes precedence over the increment
                        if (|w_strb_q) begin
                            cycle_d = '0;
                        end
                    end
                    default: bresp_d = RESP_SLVERR;
                endcase
            end
        end

        // Read execute: capture data and response, raise RVALID
        if (rd_exec) begin
            ar_full_d = 1'b0;
            rvalid_d  = 1'b1;
            rresp_d   = RESP_OKAY;
            if (ar_is_mmio) begin
                case (ar_reg)
                    REG_CTRL:   rdata_d = {{(DATA_WIDTH-1){1'b0}}, ~cpu_rst_q};
                    REG_STATUS: rdata_d = cpu_status;
                    REG_CYCLE:  rdata_d = cycle_q;
                    default: begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                endcase
            end else begin
                rdata_d = mem_rdata;
            end
        end
    end

    // State registers; reset clears everything and holds the soft CPU in reset
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            ar_full_q <= 1'b0;
            ar_addr_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            cpu_rst_q <= 1'b1;
            cycle_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ar_full_q <= ar_full_d;
            ar_addr_q <= ar_addr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cpu_rst_q <= cpu_rst_d;
            cycle_q   <= cycle_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_mmio_bridge.sv
// Directed bench for axi_lite_mem_mmio_bridge with a byte-strobed memory model.
module tb_axi_lite_mem_mmio_bridge;

    logic        clk;
    logic        rst_n;
    logic [13:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [13:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;
    logic [31:0] cpu_status;
    logic        cpu_rst;

    int n_pass;
    int n_total;
    int wen_cnt;

    logic [31:0] mem_arr [0:2047];

    axi_lite_mem_mmio_bridge dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_wen       (mem_wen),
        .mem_ren       (mem_ren),
        .mem_rdata     (mem_rdata),
        .cpu_status    (cpu_status),
        .cpu_rst       (cpu_rst)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, byte-strobed write at the clock edge
    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge clk) begin
        if (mem_wen) begin
            wen_cnt <= wen_cnt + 1;
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem_arr[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [13:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int  n;
        logic aw_hs;
        logic w_hs;
        awaddr = a; awvalid = 1'b1;
        wdata  = d; wstrb   = s; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        n = 0;
        while (!bvalid && n < 20) begin
            step();
            n++;
        end
        chk("wr_bvalid_timeout", bvalid, 1'b1);
        resp = bresp;
        bready = 1'b1;
        step();
        bready = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [13:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            step();
            n++;
        end
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            step();
            n++;
        end
        chk("rd_rvalid_timeout", rvalid, 1'b1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          w0;
        n_pass = 0; n_total = 0; wen_cnt = 0;
        for (int i = 0; i < 2048; i++) mem_arr[i] = 32'h0;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        cpu_status = 32'hCAFE0001;

        // Reset state
        step(); step();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready",  wready,  1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_rdata",   rdata,   32'h0);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_mem_wen", mem_wen, 1'b0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_awready", awready, 1'b1);
        chk("idle_arready", arready, 1'b1);

        // AW+W together at 0x0010: execute in cycle 1, BVALID in cycle 2
        awaddr = 14'h0010; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        chk("t1_c0_wready", wready, 1'b1);
        chk("t1_c0_wen", mem_wen, 1'b0);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_c1_wen",   mem_wen,   1'b1);
        chk("t1_c1_addr",  mem_addr,  11'd4);
        chk("t1_c1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t1_c1_wstrb", mem_wstrb, 4'hF);
        chk("t1_c1_bvalid", bvalid, 1'b0);
        step();
        chk("t1_c2_bvalid", bvalid, 1'b1);
        chk("t1_c2_bresp",  bresp,  2'b00);
        chk("t1_c2_wen",    mem_wen, 1'b0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("t1_b_done", bvalid, 1'b0);
        chk("t1_wen_cnt", wen_cnt, 1);

        // Read back 0x0010
        araddr = 14'h0010; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("t1_r_exec_ren", mem_ren, 1'b1);
        chk("t1_r_exec_rvalid", rvalid, 1'b0);
        step();
        chk("t1_r_rvalid", rvalid, 1'b1);
        chk("t1_r_rdata",  rdata,  32'hDEADBEEF);
        chk("t1_r_rresp",  rresp,  2'b00);
        chk("t1_r_arready_busy", arready, 1'b0);
        step();
        chk("t1_r_hold", rdata, 32'hDEADBEEF);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("t1_r_done", rvalid, 1'b0);

        // Unaligned low bits are ignored
        axi_read(14'h0013, rd, resp);
        chk("unaligned_rdata", rd, 32'hDEADBEEF);

        // W three cycles before AW, BREADY held low for 5 cycles
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("t2_wready_full", wready, 1'b0);
        chk("t2_no_exec_0", mem_wen, 1'b0);
        step();
        chk("t2_no_exec_1", mem_wen, 1'b0);
        step();
        chk("t2_no_exec_2", mem_wen, 1'b0);
        awaddr = 14'h0020; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("t2_exec_wen",  mem_wen,  1'b1);
        chk("t2_exec_addr", mem_addr, 11'd8);
        step();
        chk("t2_bvalid", bvalid, 1'b1);
        // Second pair arrives while BVALID is pending
        awaddr = 14'h0024; awvalid = 1'b1;
        wdata = 32'h55667788; wstrb = 4'hF; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_bvalid_hold", bvalid, 1'b1);
            chk("t2_blocked_wen", mem_wen, 1'b0);
            step();
            awvalid = 1'b0; wvalid = 1'b0;
            chk("t2_aw_held", awready, 1'b0);
        end
        bready = 1'b1;
        chk("t2_blocked_final", mem_wen, 1'b0);
        step();
        bready = 1'b0;
        chk("t2_b_cleared", bvalid, 1'b0);
        chk("t2_second_wen",  mem_wen,  1'b1);
        chk("t2_second_addr", mem_addr, 11'd9);
        step();
        chk("t2_second_bvalid", bvalid, 1'b1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        axi_read(14'h0020, rd, resp);
        chk("t2_rd_first", rd, 32'h11223344);
        axi_read(14'h0024, rd, resp);
        chk("t2_rd_second", rd, 32'h55667788);

        // MMIO with cpu_rst still asserted
        axi_write(14'h2000, 32'h1, 4'h0, resp);
        chk("ctrl_nostrb_resp", resp, 2'b00);
        chk("ctrl_nostrb_rst", cpu_rst, 1'b1);
        axi_read(14'h200C, rd, resp);
        chk("bad_rd_resp", resp, 2'b10);
        chk("bad_rd_data", rd, 32'h0);
        axi_write(14'h2010, 32'hFFFF_FFFF, 4'hF, resp);
        chk("bad_wr_resp", resp, 2'b10);
        axi_write(14'h2004, 32'h1234, 4'hF, resp);
        chk("status_wr_resp", resp, 2'b00);
        axi_read(14'h2004, rd, resp);
        chk("status_rd", rd, 32'hCAFE0001);
        axi_read(14'h2000, rd, resp);
        chk("ctrl_rd_inreset", rd, 32'h0);
        axi_read(14'h2008, rd, resp);
        chk("cycle_held", rd, 32'h0);

        // Release the soft CPU and let the counter run
        axi_write(14'h2000, 32'h1, 4'h1, resp);
        chk("ctrl_wr_resp", resp, 2'b00);
        chk("ctrl_released", cpu_rst, 1'b0);
        axi_read(14'h2000, rd, resp);
        chk("ctrl_rd_run", rd, 32'h1);
        for (int i = 0; i < 10; i++) step();
        axi_read(14'h2008, rd, resp);
        chk("cycle_run_ge10", (rd >= 32'd10), 1'b1);
        axi_write(14'h2008, 32'h0, 4'hF, resp);
        axi_read(14'h2008, rd, resp);
        chk("cycle_cleared_small", (rd <= 32'd4), 1'b1);
        axi_write(14'h2000, 32'h0, 4'h2, resp);
        chk("ctrl_strb_hi_ignored", cpu_rst, 1'b0);

        // AR and write execute in the same cycle: write first, read next
        awaddr = 14'h0040; awvalid = 1'b1;
        wdata = 32'hA5A5A5A5; wstrb = 4'h3; wvalid = 1'b1;
        araddr = 14'h0020; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t5_n_wen",   mem_wen,   1'b1);
        chk("t5_n_ren",   mem_ren,   1'b0);
        chk("t5_n_wstrb", mem_wstrb, 4'h3);
        step();
        chk("t5_n1_wen",  mem_wen, 1'b0);
        chk("t5_n1_ren",  mem_ren, 1'b1);
        chk("t5_n1_addr", mem_addr, 11'd8);
        chk("t5_bvalid",  bvalid,  1'b1);
        chk("t5_bresp",   bresp,   2'b00);
        step();
        chk("t5_rvalid", rvalid, 1'b1);
        chk("t5_rdata",  rdata,  32'h11223344);
        bready = 1'b1; rready = 1'b1;
        step();
        bready = 1'b0; rready = 1'b0;
        axi_read(14'h0040, rd, resp);
        chk("t5_partial_word", rd, 32'h0000A5A5);

        // Asynchronous reset with AW held and W pending
        awaddr = 14'h0050; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("t6_aw_held", awready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_wready",  wready,  1'b0);
        chk("t6_async_arready", arready, 1'b0);
        chk("t6_async_cpu_rst", cpu_rst, 1'b1);
        chk("t6_async_rdata",   rdata,   32'h0);
        step();
        rst_n = 1'b1;
        w0 = wen_cnt;
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t6_no_wen", wen_cnt, w0);
        chk("t6_aw_empty", awready, 1'b1);
        chk("t6_w_held", wready, 1'b0);
        chk("t6_bvalid", bvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
